// File: rtl/spi_xfer_ctrl.sv
// Register-bus sequencer that runs one full-duplex SPI byte transfer per start request.
// Optional poll timeout is compiled in with `define SPI_POLL_TIMEOUT_EN.
module spi_xfer_ctrl #(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]  SS_MASK        = DATA_WIDTH'(8'h01),
  parameter int unsigned            TIMEOUT_CYCLES = 1024
) (
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] o_data,
  output logic                  I_TX_EN,
  output logic [2:0]            I_WADDR,
  output logic [DATA_WIDTH-1:0] I_WDATA,
  output logic                  I_RX_EN,
  output logic [2:0]            I_RADDR,
  input  logic [DATA_WIDTH-1:0] O_RDATA,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  is_sending,
  output logic [5:0]            wr_index
);

  localparam logic [2:0] ADDR_RXDATA = 3'd0;
  localparam logic [2:0] ADDR_TXDATA = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_SSMASK = 3'd3;
  localparam int unsigned BIT_TRDY = 5;
  localparam int unsigned BIT_RRDY = 6;

  // Each strobe is registered on entry to the state that owns it, so it is
  // visible during that state; read data is valid in the following state.
  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_POLL_T, S_WAIT_T, S_CHK_T, S_WR_TX,
    S_POLL_R, S_WAIT_R, S_CHK_R, S_RD_RX, S_RD_WAIT, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_tx_en;
  logic                  r_rx_en;
  logic [2:0]            r_waddr;
  logic [2:0]            r_raddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_i_data;
  logic                  r_busy;
  logic [5:0]            r_wr_index;
  logic                  r_rdy;

`ifdef SPI_POLL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_poll_cnt;
  logic             w_in_poll;
  logic             w_poll_ok;

  assign w_in_poll = r_state inside {S_POLL_T, S_WAIT_T, S_CHK_T, S_POLL_R, S_WAIT_R, S_CHK_R};
  assign w_poll_ok = (r_state == S_CHK_T || r_state == S_CHK_R) && r_rdy;
`else
  // Polls wait indefinitely; TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      r_state    <= S_IDLE;
      r_tx_en    <= 1'b0;
      r_rx_en    <= 1'b0;
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_wdata    <= '0;
      r_i_data   <= '0;
      r_busy     <= 1'b0;
      r_wr_index <= '0;
      r_rdy      <= 1'b0;
`ifdef SPI_POLL_TIMEOUT_EN
      r_poll_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // the same cycle, which keeps every strobe exactly one cycle wide.
      r_tx_en <= 1'b0;
      r_rx_en <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_busy  <= 1'b1;
          r_tx_en <= 1'b1;
          r_waddr <= ADDR_SSMASK;
          r_wdata <= SS_MASK;
          r_state <= S_SEL;
        end
        S_SEL: begin
          r_rx_en <= 1'b1;
          r_raddr <= ADDR_STATUS;
          r_state <= S_POLL_T;
        end
        S_POLL_T: r_state <= S_WAIT_T;
        S_WAIT_T: begin
          r_rdy   <= O_RDATA[BIT_TRDY];
          r_state <= S_CHK_T;
        end
        S_CHK_T: if (r_rdy) begin
          r_tx_en <= 1'b1;
          r_waddr <= ADDR_TXDATA;
          r_wdata <= o_data;
          r_state <= S_WR_TX;
        end else begin
          r_rx_en <= 1'b1;
          r_raddr <= ADDR_STATUS;
          r_state <= S_POLL_T;
        end
        S_WR_TX: begin
          r_rx_en <= 1'b1;
          r_raddr <= ADDR_STATUS;
          r_state <= S_POLL_R;
        end
        S_POLL_R: r_state <= S_WAIT_R;
        S_WAIT_R: begin
          r_rdy   <= O_RDATA[BIT_RRDY];
          r_state <= S_CHK_R;
        end
        S_CHK_R: begin
          r_rx_en <= 1'b1;
          r_raddr <= r_rdy ? ADDR_RXDATA : ADDR_STATUS;
          r_state <= r_rdy ? S_RD_RX : S_POLL_R;
        end
        S_RD_RX: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_i_data   <= O_RDATA;
          r_wr_index <= r_wr_index + 6'd1;
          r_busy     <= 1'b0;
          r_state    <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
`ifdef SPI_POLL_TIMEOUT_EN
      // The counter spans one whole poll phase, including its re-polls.
      if (r_state == S_SEL || r_state == S_WR_TX) begin
        r_poll_cnt <= '0;
      end else if (w_in_poll) begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end
      if (w_in_poll && !w_poll_ok && r_poll_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        r_rx_en  <= 1'b0;
        r_i_data <= '1;
        r_busy   <= 1'b0;
        r_state  <= S_DONE;
      end
`endif
    end
  end

  assign I_TX_EN    = r_tx_en;
  assign I_WADDR    = r_waddr;
  assign I_WDATA    = r_wdata;
  assign I_RX_EN    = r_rx_en;
  assign I_RADDR    = r_raddr;
  assign i_data     = r_i_data;
  assign is_sending = r_busy;
  assign wr_index   = r_wr_index;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a behavioural SPI core responder, a bus
// monitor, and directed plus randomized transfers checked against expected bus traffic.
module tb_spi_xfer_ctrl;

`ifdef SPI_POLL_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic       I_CLK   = 1'b0;
  logic       I_RESET = 1'b1;
  logic       start   = 1'b0;
  logic [7:0] o_data  = 8'h00;
  logic [7:0] O_RDATA = 8'h00;
  logic       I_TX_EN, I_RX_EN, is_sending;
  logic [2:0] I_WADDR, I_RADDR;
  logic [7:0] I_WDATA, i_data;
  logic [5:0] wr_index;

  spi_xfer_ctrl #(
    .DATA_WIDTH     (8),
    .SS_MASK        (8'h01),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .I_CLK      (I_CLK),
    .I_RESET    (I_RESET),
    .start      (start),
    .o_data     (o_data),
    .I_TX_EN    (I_TX_EN),
    .I_WADDR    (I_WADDR),
    .I_WDATA    (I_WDATA),
    .I_RX_EN    (I_RX_EN),
    .I_RADDR    (I_RADDR),
    .O_RDATA    (O_RDATA),
    .i_data     (i_data),
    .is_sending (is_sending),
    .wr_index   (wr_index)
  );

  always #5 I_CLK = ~I_CLK;

  int n_chk = 0;
  int n_bad = 0;

  // Core behaviour knobs, set by the stimulus.
  int         cfg_hold_t = 0;
  int         cfg_hold_r = 0;
  logic [7:0] cfg_rx     = 8'h00;
  bit         cfg_stuck  = 1'b0;

  // Core state and bus logs.
  int          t_polls = 0;
  int          r_polls = 0;
  bit          tx_done = 1'b0;
  logic [10:0] write_q[$];
  logic [2:0]  read_q[$];
  int          len_q[$];
  int          n_done = 0, cur_len = 0, cur_gap = 0, min_gap = 1000;
  bit          seen_fall = 1'b0;
  int          viol_both = 0, viol_long = 0, viol_idle = 0, viol_chg = 0;
  logic        prev_tx = 1'b0, prev_rx = 1'b0, prev_busy = 1'b0, prev_rst = 1'b1;
  logic [7:0]  prev_idata = 8'h00;
  logic [5:0]  prev_idx = 6'd0;

  always @(posedge I_CLK) begin
    if (I_TX_EN && I_RX_EN) viol_both++;
    if ((I_TX_EN && prev_tx) || (I_RX_EN && prev_rx)) viol_long++;
    if ((I_TX_EN || I_RX_EN) && !is_sending) viol_idle++;
    if (!I_RESET && !prev_rst && (i_data !== prev_idata || wr_index !== prev_idx)
        && !(prev_busy && !is_sending)) viol_chg++;

    if (is_sending) begin
      cur_len++;
      if (!prev_busy && seen_fall && cur_gap < min_gap) min_gap = cur_gap;
    end else begin
      if (prev_busy) begin
        len_q.push_back(cur_len);
        cur_len   = 0;
        cur_gap   = 0;
        seen_fall = 1'b1;
        n_done++;
      end
      cur_gap++;
    end

    // SPI core responder: read data appears the cycle after the read strobe.
    if (I_TX_EN) begin
      write_q.push_back({I_WADDR, I_WDATA});
      if (I_WADDR == 3'd3) begin
        t_polls = 0;
        r_polls = 0;
        tx_done = 1'b0;
      end else if (I_WADDR == 3'd1) begin
        tx_done = 1'b1;
      end
    end
    if (I_RX_EN) begin
      read_q.push_back(I_RADDR);
      if (I_RADDR == 3'd2) begin
        if (cfg_stuck) begin
          O_RDATA <= 8'h00;
        end else if (!tx_done) begin
          O_RDATA <= (t_polls >= cfg_hold_t) ? 8'h60 : 8'h50;
          t_polls++;
        end else begin
          O_RDATA <= (r_polls >= cfg_hold_r) ? 8'h60 : 8'h30;
          r_polls++;
        end
      end else if (I_RADDR == 3'd0) begin
        O_RDATA <= cfg_rx;
        tx_done = 1'b0;
      end else begin
        O_RDATA <= 8'h00;
      end
    end else begin
      O_RDATA <= 8'($urandom);
    end

    prev_tx    = I_TX_EN;
    prev_rx    = I_RX_EN;
    prev_busy  = is_sending;
    prev_rst   = I_RESET;
    prev_idata = i_data;
    prev_idx   = wr_index;
  end

  int exp_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge I_CLK);
  endtask

  task automatic wait_done(input int base, input int budget, input string tag);
    int k = 0;
    while (n_done <= base && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_done"}, 32'(n_done > base), 32'd1);
  endtask

  // Expected traffic: SSMASK then TXDATA write; (ht+1)+(hr+1) STATUS reads then one RXDATA read.
  task automatic run_xfer(input int ht, input int hr, input logic [7:0] tx,
                          input logic [7:0] rx, input string tag);
    int wb, rb, base, bad_w, bad_r, n_rd;
    cfg_hold_t = ht;
    cfg_hold_r = hr;
    cfg_rx     = rx;
    o_data     = tx;
    wb   = write_q.size();
    rb   = read_q.size();
    base = n_done;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(base, 60 + 4 * (ht + hr), tag);
    exp_idx = (exp_idx + 1) % 64;
    n_rd = ht + hr + 3;

    check({tag, "_nwr"}, 32'(write_q.size() - wb), 32'd2);
    bad_w = 0;
    if (write_q.size() >= wb + 2) begin
      if (write_q[wb] !== {3'd3, 8'h01}) bad_w++;
      if (write_q[wb + 1] !== {3'd1, tx}) bad_w++;
    end else begin
      bad_w = 99;
    end
    check({tag, "_wrseq"}, 32'(bad_w), 32'd0);

    check({tag, "_nrd"}, 32'(read_q.size() - rb), 32'(n_rd));
    bad_r = 0;
    for (int i = 0; i < n_rd; i++) begin
      if (rb + i >= read_q.size()) bad_r++;
      else if (read_q[rb + i] !== ((i == n_rd - 1) ? 3'd0 : 3'd2)) bad_r++;
    end
    check({tag, "_rdseq"}, 32'(bad_r), 32'd0);

    check({tag, "_idata"}, 32'(i_data), 32'(rx));
    check({tag, "_idx"}, 32'(wr_index), 32'(exp_idx));
    check({tag, "_idle"}, 32'(is_sending), 32'd0);
  endtask

  initial begin
    int base, wb, rb, k;

    // Reset state
    I_RESET = 1'b1;
    tick(3);
    check("rst_busy",  32'(is_sending), 32'd0);
    check("rst_txen",  32'(I_TX_EN),    32'd0);
    check("rst_rxen",  32'(I_RX_EN),    32'd0);
    check("rst_waddr", 32'(I_WADDR),    32'd0);
    check("rst_raddr", 32'(I_RADDR),    32'd0);
    check("rst_wdata", 32'(I_WDATA),    32'd0);
    check("rst_idata", 32'(i_data),     32'd0);
    check("rst_idx",   32'(wr_index),   32'd0);
    I_RESET = 1'b0;
    tick(2);

    // Fast core: exact 10-cycle busy window
    run_xfer(0, 0, 8'h46, 8'h5A, "fast");
    check("fast_len", 32'(len_q[$]), 32'd10);

    // Slow core: 6 STATUS reads for TX, 4 for RX
    run_xfer(5, 3, 8'($urandom), 8'($urandom), "slow");

    for (int i = 0; i < 6; i++) begin
      run_xfer(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               8'($urandom), 8'($urandom), "rand");
    end

    // Start pulsed while busy must not launch another transfer
    cfg_hold_t = 2;
    cfg_hold_r = 2;
    cfg_rx     = 8'hA7;
    o_data     = 8'h3C;
    base = n_done;
    wb   = write_q.size();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(8);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(base, 100, "busy_start");
    exp_idx = (exp_idx + 1) % 64;
    tick(15);
    check("busy_start_ndone", 32'(n_done - base), 32'd1);
    check("busy_start_nwr",   32'(write_q.size() - wb), 32'd2);
    check("busy_start_idx",   32'(wr_index), 32'(exp_idx));
    check("busy_start_idata", 32'(i_data), 32'h0A7);

    // Reset during the RX poll phase
    cfg_hold_t = 0;
    cfg_hold_r = 1000;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    k = 0;
    while (!tx_done && k < 50) begin
      tick(1);
      k++;
    end
    check("rstpr_reached", 32'(tx_done), 32'd1);
    tick(3);
    I_RESET = 1'b1;
    tick(1);
    check("rstpr_busy",  32'(is_sending), 32'd0);
    check("rstpr_txen",  32'(I_TX_EN),    32'd0);
    check("rstpr_rxen",  32'(I_RX_EN),    32'd0);
    check("rstpr_idx",   32'(wr_index),   32'd0);
    check("rstpr_idata", 32'(i_data),     32'd0);
    rb = read_q.size();
    wb = write_q.size();
    tick(2);
    I_RESET = 1'b0;
    exp_idx = 0;
    tick(10);
    check("rstpr_quiet", 32'((read_q.size() - rb) + (write_q.size() - wb)), 32'd0);

    // Start held high for 64 back-to-back transfers
    cfg_hold_t = 0;
    cfg_hold_r = 0;
    cfg_rx     = 8'hC3;
    base = n_done;
    start = 1'b1;
    k = 0;
    while (n_done < base + 64 && k < 64 * 20) begin
      tick(1);
      k++;
    end
    start = 1'b0;
    tick(12);
    check("hold64_count", 32'(n_done - base), 32'd64);
    check("hold64_idx",   32'(wr_index), 32'd0);
    check("hold64_idata", 32'(i_data), 32'h0C3);
    check("hold64_gap",   32'(min_gap >= 1), 32'd1);
    check("hold64_idle",  32'(is_sending), 32'd0);

`ifdef SPI_POLL_TIMEOUT_EN
    // STATUS stuck at zero: abort with all-ones data and no index change
    cfg_stuck = 1'b1;
    base = n_done;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(base, 40, "tmo");
    check("tmo_idata", 32'(i_data), 32'h0FF);
    check("tmo_idx",   32'(wr_index), 32'(exp_idx));
    check("tmo_len",   32'(len_q[$] <= 17), 32'd1);
    cfg_stuck = 1'b0;
    tick(3);
`endif

    // Bus-protocol invariants collected over the whole run
    check("inv_both_strobes", 32'(viol_both), 32'd0);
    check("inv_strobe_width", 32'(viol_long), 32'd0);
    check("inv_idle_strobe",  32'(viol_idle), 32'd0);
    check("inv_out_change",   32'(viol_chg),  32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
